cc_completion_formatter: RTL

Sits directly downstream of the user register/DMA logic on the Completer Completion (CC) path. Accepts single-cycle completion requests (descriptor fields plus up to 4 DW of read data) and buffers them in a small FIFO. Each request becomes a single-beat 256-bit AXI4-Stream CC TLP for the PCIe hard IP: 3-DW descriptor in DW0-2, payload from DW3. The FIFO decouples the producer's fire-and-forget cc_valid pulse from hard-IP backpressure on tready.

---
 rtl/cc_completion_formatter_if.sv | 35 +++
 rtl/cc_completion_formatter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cc_completion_formatter_if.sv
// -----------------------------------------------------------------------------
// cc_completion_formatter_if
//   AXI4-Stream Completer Completion (CC) bus between the completion formatter
//   and the PCIe hard IP.
//
//   tdata  : TLP beat (DATA_WIDTH bits)
//   tkeep  : DW-valid mask (DATA_WIDTH/32 bits)
//   tlast  : end of TLP
//   tuser  : 33-bit sideband
//   tvalid : beat valid (source -> sink)
//   tready : sink accepts beat (sink -> source)
//
//   master : the formatter (drives the beat, samples tready)
//   slave  : the hard IP side (samples the beat, drives tready)
// -----------------------------------------------------------------------------
interface cc_completion_formatter_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0]    tdata;
  logic [DATA_WIDTH/32-1:0] tkeep;
  logic                     tlast;
  logic [32:0]              tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/cc_completion_formatter.sv
// -----------------------------------------------------------------------------
// cc_completion_formatter
//   Buffers single-cycle completion requests from the register/DMA logic in a
//   small FIFO and emits each one as a single-beat 256-bit AXI4-Stream CC TLP:
//   3-DW completion descriptor in DW0-2, up to 4 DW of payload from DW3.
//
// Ports:
//   clk, rst_n          : core clock, asynchronous active-low reset
//   completer_id        : own Bus:Dev:Func, placed in descriptor DW2
//   cc_valid / cc_ready : request strobe / room available (registered full)
//   cc_requester_id, cc_tag, cc_tc, cc_lower_addr, cc_dword_count,
//   cc_status, cc_data  : completion fields captured on cc_valid && cc_ready
//   cc_last             : accepted and ignored (always single-beat)
//   m_axis_cc           : CC AXI4-Stream master (cc_completion_formatter_if)
//   overflow_err        : sticky, set when a request arrives while full
//
// Optional build macro:
//   CC_STATS_EN : adds cpl_sent_cnt / cpl_drop_cnt (16-bit, wrapping)
// -----------------------------------------------------------------------------
module cc_completion_formatter #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               completer_id,
  input  logic                      cc_valid,
  output logic                      cc_ready,
  input  logic [15:0]               cc_requester_id,
  input  logic [7:0]                cc_tag,
  input  logic [2:0]                cc_tc,
  input  logic [6:0]                cc_lower_addr,
  input  logic [10:0]               cc_dword_count,
  input  logic [2:0]                cc_status,
  input  logic [DATA_WIDTH/2-1:0]   cc_data,
  input  logic                      cc_last,
  cc_completion_formatter_if.master m_axis_cc,
  output logic                      overflow_err
`ifdef CC_STATS_EN
  ,
  output logic [15:0]               cpl_sent_cnt,
  output logic [15:0]               cpl_drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = DATA_WIDTH / 32;

  typedef struct packed {
    logic [15:0]             requester_id;
    logic [7:0]              tag;
    logic [2:0]              tc;
    logic [6:0]              lower_addr;
    logic [10:0]             dword_count;
    logic [2:0]              status;
    logic [DATA_WIDTH/2-1:0] data;
  } cc_entry_t;

  cc_entry_t             mem [FIFO_DEPTH];
  cc_entry_t             head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           fifo_count;
  logic [AW+1:0]         occupancy;
  logic                  push, drop, load, pop;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KW-1:0]         out_keep;
  logic                  out_last;

  logic                  sc;
  logic [10:0]           dw_field;
  logic [12:0]           byte_count;
  logic [2:0]            pay_cnt;
  logic [159:0]          payload;
  logic [DATA_WIDTH-1:0] nxt_tdata;
  logic [KW-1:0]         nxt_tkeep;

  logic                  unused_cc_last;
  assign unused_cc_last = cc_last;

  // Occupancy counts the output register as well, so FIFO_DEPTH bounds the
  // number of completions in flight. It is built from registers only: a pop in
  // the same cycle does not reopen the slot until the next cycle.
  assign occupancy = {1'b0, fifo_count} + (AW+2)'(out_valid);
  assign cc_ready  = occupancy < (AW+2)'(FIFO_DEPTH);

  assign push = cc_valid && cc_ready;
  assign drop = cc_valid && !cc_ready;
  assign load = !out_valid || m_axis_cc.tready;
  assign pop  = load && (fifo_count != '0);

  // NOTE: storage is not reset; only the pointers and count define which
  // entries are meaningful, so a reset on the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{requester_id: cc_requester_id, tag: cc_tag, tc: cc_tc,
                       lower_addr: cc_lower_addr, dword_count: cc_dword_count,
                       status: cc_status, data: cc_data};
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
      else if (!push && pop) fifo_count <= fifo_count - (AW+1)'(1);
      if (drop) overflow_err <= 1'b1;
    end
  end

  // Descriptor and payload formatting from the FIFO head.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    head       = mem[rd_ptr];
    sc         = (head.status == 3'b000);
    dw_field   = '0;
    byte_count = 13'd4;
    pay_cnt    = 3'd0;
    payload    = {32'h0, head.data};
    nxt_tkeep  = '0;

    if (sc) begin
      dw_field = head.dword_count;
      // dword_count 0 encodes 1024 DW; payload beyond 4 DW is not carried.
      if (head.dword_count == 11'd0) begin
        byte_count = 13'h1000;
        pay_cnt    = 3'd4;
      end else begin
        byte_count = {head.dword_count, 2'b00};
        pay_cnt    = (head.dword_count > 11'd4) ? 3'd4 : head.dword_count[2:0];
      end
    end

    for (int i = 0; i < 5; i++) begin
      if (i >= int'(pay_cnt)) payload[32*i +: 32] = 32'h0;
    end
    for (int i = 0; i < KW; i++) begin
      nxt_tkeep[i] = (i < 3 + int'(pay_cnt));
    end

    nxt_tdata = {payload,
                 // DW2: rsvd, attr, tc, completer_id_en, completer_id, tag
                 1'b0, 3'b000, head.tc, 1'b1, completer_id, head.tag,
                 // DW1: requester_id, rsvd, poison, status, dword_count
                 head.requester_id, 1'b0, 1'b0, head.status, dw_field,
                 // DW0: rsvd, byte_count, rsvd, AT, rsvd, lower_addr
                 3'b000, byte_count, 6'h00, 2'b00, 1'b0, head.lower_addr};
  end

  // Output register: holds the beat while stalled, refills from the head
  // whenever it is empty or its beat is being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= pop;
      out_last  <= pop;
      out_data  <= pop ? nxt_tdata : '0;
      out_keep  <= pop ? nxt_tkeep : '0;
    end
  end

  assign m_axis_cc.tvalid = out_valid;
  assign m_axis_cc.tdata  = out_data;
  assign m_axis_cc.tkeep  = out_keep;
  assign m_axis_cc.tlast  = out_last;
  assign m_axis_cc.tuser  = '0;

`ifdef CC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_sent_cnt <= '0;
      cpl_drop_cnt <= '0;
    end else begin
      if (out_valid && m_axis_cc.tready) cpl_sent_cnt <= cpl_sent_cnt + 16'd1;
      if (drop)                          cpl_drop_cnt <= cpl_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
